// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the multi-channel clock generator.
package clk_gen_pkg;

  // Default width of counters, periods and high times.
  localparam int CNT_W_DEF  = 32;

  // Shortest period a channel can run; one high and one low cycle.
  localparam int MIN_PERIOD = 2;

  // Channel-index width; at least one bit so a single-channel build still has a port.
  function automatic int CH_W(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_gen_channel.sv
// One divider channel: free-running counter, active and shadow period/high
// registers, pending-update flag and registered clk_out/tick.
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = 100_000_000,
  parameter int unsigned DEFAULT_HIGH   = 50_000_000
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_p, act_h;
  logic [CNT_W-1:0] sh_p, sh_h;
  logic             pend;
  logic             run;

  logic [CNT_W-1:0] eff_p, eff_h;
  logic             eff_pend;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] nxt_p, nxt_h, nxt_cnt;

  // Next-state: a write this cycle overrides the shadow so it can land on this
  // very wrap; the shadow is promoted only at a wrap or while disabled, so a
  // running period is never cut or stretched. The first enabled edge only
  // starts the period at count 0; it does not advance.
  always_comb begin
    eff_p    = wr ? wr_period : sh_p;
    eff_h    = wr ? wr_high   : sh_h;
    eff_pend = wr | pend;
    wrap     = run && (cnt == act_p - ONE);
    apply    = eff_pend && (!en || wrap);
    nxt_p    = apply ? eff_p : act_p;
    nxt_h    = apply ? eff_h : act_h;
    nxt_cnt  = (!en || !run || wrap) ? '0 : cnt + ONE;
  end

  // Counter, configuration registers and pending flag.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      act_p <= DEF_P;
      act_h <= DEF_H;
      sh_p  <= DEF_P;
      sh_h  <= DEF_H;
      pend  <= 1'b0;
    end else begin
      run   <= en;
      cnt   <= nxt_cnt;
      act_p <= nxt_p;
      act_h <= nxt_h;
      sh_p  <= eff_p;
      sh_h  <= eff_h;
      pend  <= eff_pend && !apply;
    end
  end

  // Outputs are registered from the next count so they line up with cnt.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      clk_out <= en && (nxt_cnt < nxt_h);
      tick    <= en && (nxt_cnt == nxt_p - ONE);
    end
  end

endmodule

// File: rtl/multi_clk_gen.sv
// NUM_CH independent programmable clock dividers with a shared config write
// port. Invalid writes are dropped and flagged on cfg_err for one cycle.
module multi_clk_gen
  import clk_gen_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned DEFAULT_PERIOD = 100_000_000,
  parameter int unsigned DEFAULT_HIGH   = 50_000_000
) (
  input  logic                      clk_100MHz,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      cfg_wr,
  input  logic [CH_W(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic [CNT_W-1:0]          cfg_high,
  output logic                      cfg_err,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick
);

  localparam int CHW = CH_W(NUM_CH);

  logic              cfg_ok;
  logic [NUM_CH-1:0] wr_sel;

  // Index is widened before the range check so non-power-of-2 channel
  // counts reject the unused codes.
  assign cfg_ok = (32'(cfg_ch) < 32'(NUM_CH)) &&
                  (cfg_period >= CNT_W'(MIN_PERIOD));

  // Rejection strobe, one cycle per bad write.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) cfg_err <= 1'b0;
    else          cfg_err <= cfg_wr && !cfg_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = cfg_wr && cfg_ok && (cfg_ch == CHW'(i));

    clk_gen_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_HIGH   (DEFAULT_HIGH)
    ) u_ch (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .en         (ch_en[i]),
      .wr         (wr_sel[i]),
      .wr_period  (cfg_period),
      .wr_high    (cfg_high),
      .clk_out    (clk_out[i]),
      .tick       (tick[i])
    );
  end

endmodule

// File: doc/multi_clk_gen.md
Name: multi_clk_gen

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio divider.
- Produces NUM_CH independent divided-clock outputs, plus a one-cycle tick strobe per channel, all in the clk_100MHz domain.
- Period and high time are runtime-programmable per channel through a simple write port, with glitch-free shadow update at the period boundary.
- Feeds LED/PWM/UART-rate consumers in the lab designs.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, counter/period/high-time width in bits.
- DEFAULT_PERIOD, 100_000_000, per-channel period (in clk cycles) loaded at reset; must be ≥ 2.
- DEFAULT_HIGH, 50_000_000, per-channel high time loaded at reset; must be ≤ DEFAULT_PERIOD.

Ports:
- clk_100MHz  in  1  system clock; sole clock.
- reset_n  in  1  synchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- cfg_wr  in  1  single-cycle config write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_period  in  CNT_W  new period P in clk cycles.
- cfg_high  in  CNT_W  new high time H in clk cycles.
- cfg_err  out  1  one-cycle pulse, registered; a write was rejected.
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle strobe on the last cycle of each period, registered.

Behaviour:
- Reset (reset_n low at a clk_100MHz edge):
  - Every channel: count=0, active P/H = DEFAULT_*, pending flag cleared.
  - clk_out=0, tick=0, cfg_err=0.
  - Reset wins over every other input in that cycle, including cfg_wr.
  - Reset asserted mid-period aborts the period immediately; no tick is emitted.
- Per-channel counter:
  - While ch_en[i]=1, count runs 0..P-1 and wraps to 0. Division ratio is exactly P.
  - tick[i]=1 exactly in the cycle where count==P-1.
  - clk_out[i]=1 iff count < H, registered from next-count so it aligns with count.
  - H=0 gives constant 0. H≥P gives constant 1, with tick still pulsing.
- Enable:
  - ch_en[i]=0: count held at 0, clk_out[i]=0, tick[i]=0. A pending config is applied immediately.
  - When ch_en[i] is first sampled high at an edge, count=0 and clk_out[i]=(H>0) after that same edge.
  - Deassertion takes effect at the next edge, cutting the period short with no tick.
- Config write (cfg_wr=1 at an edge):
  - Rejected if cfg_ch ≥ NUM_CH or cfg_period < 2. On rejection: cfg_err=1 for one cycle, no state change.
  - Otherwise P/H are latched into the channel's shadow and its pending flag is set. cfg_err=0.
  - Multiple writes before a boundary: the last one wins.
- Shadow apply:
  - At the edge where count==P-1 (wrap) and pending=1: active P/H ← shadow, pending ← 0, and the new period starts at count=0.
  - cfg_wr to the same channel in the same cycle as its wrap: the newly written values are applied at that wrap.
  - The currently running period is never truncated or stretched by a write while enabled.
- Channels are fully independent. There is no cross-channel phase alignment.
- Arithmetic: all compares are unsigned CNT_W. The counter never exceeds P-1, so no overflow is possible.

Decomposition:
- Package clk_gen_pkg: CNT_W default, a CH_W function (max(1,$clog2(NUM_CH))), and localparam MIN_PERIOD=2.
- Sub-module clk_gen_channel holds one counter, the active/shadow registers, the pending flag and the output regs.
- The top instantiates NUM_CH channels via generate and contains the write-port decode plus cfg_err.

Test Plan:
- Reset sequence: assert reset_n=0 for 3 cycles with DEFAULT_PERIOD=10, DEFAULT_HIGH=5, ch_en=all 1 → all outputs 0 during reset; afterwards clk_out high 5 / low 5 cycles; tick every 10th cycle, coincident with the last low cycle.
- Runtime reprogram: write ch1 P=4,H=1 mid-period of a 10-cycle period → the current 10-cycle period completes; next period is 1 high / 3 low; tick period becomes 4.
- Write coincident with wrap: on ch0, write P=6,H=3 in the cycle tick[0]=1 → the very next period is 6 cycles.
- Back-to-back writes P=8 then P=12 before wrap → only P=12 is applied.
- Rejections: write cfg_period=1 → cfg_err pulse, behaviour unchanged. Write cfg_ch=NUM_CH (non-power-of-2 config, NUM_CH=3) → cfg_err pulse.
- Duty extremes: H=0 → clk_out stays 0. H=P=7 → clk_out stays 1 while tick still pulses every 7 cycles.
- Enable/reset mid-operation: drop ch_en[2] at count=3 → next edge clk_out=0, no tick. Re-enable → count restarts at 0 with clk_out=1. Pull reset_n low at count=5 → defaults restored, pending write discarded.
